sysid_check_ctrl: RTL

- Avalon-MM read master that sequences the system ID slave: reads ID word (address 0), then timestamp word (address 1).
- Compares both against build-time expected values; reports pass/fail to boot firmware and the status LEDs.
- Optional periodic re-check; saturating mismatch counter.
- Sits beside the Nios boot path, attached to the sysid slave through the interconnect.

---
 rtl/sysid_check_ctrl_if.sv | 21 ++
 rtl/sysid_check_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_ctrl_if.sv
// Avalon-MM read channel between the sysid checker (master) and the sysid slave.
//   avm_address  : word select, 0 = ID word, 1 = timestamp word
//   avm_read     : one-cycle read strobe
//   avm_readdata : 32-bit read data returned by the slave
interface sysid_check_ctrl_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata
  );
endinterface

// File: rtl/sysid_check_ctrl.sv
// System ID checker: reads the sysid ID word (address 0) and then the timestamp word
// (address 1) over Avalon-MM, compares both with build-time values and reports the
// result to boot firmware / status LEDs. Optional periodic re-check.
//
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   start          : one-cycle request to begin a check (ignored while busy)
//   clear_errcnt   : zeroes err_count (wins over a same-cycle increment)
//   avm            : Avalon-MM master port (address, read, readdata)
//   busy           : high in every state except idle
//   done           : one-cycle pulse when a check completes
//   pass / fail    : result of the last completed check
//   id_value       : captured address-0 word
//   ts_value       : captured address-1 word
//   err_count      : saturating count of failed checks
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1480283514,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned PERIOD             = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 clear_errcnt,
  sysid_check_ctrl_if.master   avm,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value,
  output logic [7:0]           err_count
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRdId = 3'd1;
  localparam logic [2:0] StWtId = 3'd2;
  localparam logic [2:0] StRdTs = 3'd3;
  localparam logic [2:0] StWtTs = 3'd4;
  localparam logic [2:0] StCmp  = 3'd5;
  localparam logic [2:0] StHold = 3'd6;

  localparam int unsigned PW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0] PER_ONE  = PW'(1);
  localparam logic [2:0]    LAT_LAST = 3'(READ_LATENCY);

  logic [2:0]    state_q, state_d;
  logic [2:0]    wait_q, wait_d;
  logic [PW-1:0] per_q, per_d;
  logic          addr_q, addr_d;
  logic [31:0]   id_q, id_d;
  logic [31:0]   ts_q, ts_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic [7:0]    err_q, err_d;

  // Period expiry only matters when periodic re-check is enabled.
  logic per_expired;
  assign per_expired = (PERIOD != 0) && (per_q == PER_LAST);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    per_d   = per_q;
    addr_d  = addr_q;
    id_d    = id_q;
    ts_d    = ts_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;

    if (clear_errcnt) begin
      err_d = 8'd0;
    end

    unique case (state_q)
      StIdle: begin
        // A start coinciding with expiry still launches just one check.
        if (start || per_expired) begin
          state_d = StRdId;
          addr_d  = 1'b0;
          per_d   = '0;
        end else if (PERIOD != 0) begin
          per_d = per_q + PER_ONE;
        end
      end
      StRdId: begin
        if (READ_LATENCY == 0) begin
          id_d    = avm.avm_readdata;
          state_d = StRdTs;
          addr_d  = 1'b1;
        end else begin
          wait_d  = 3'd1;
          state_d = StWtId;
        end
      end
      StWtId: begin
        if (wait_q == LAT_LAST) begin
          id_d    = avm.avm_readdata;
          state_d = StRdTs;
          addr_d  = 1'b1;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      StRdTs: begin
        if (READ_LATENCY == 0) begin
          ts_d    = avm.avm_readdata;
          state_d = StCmp;
        end else begin
          wait_d  = 3'd1;
          state_d = StWtTs;
        end
      end
      StWtTs: begin
        if (wait_q == LAT_LAST) begin
          ts_d    = avm.avm_readdata;
          state_d = StCmp;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      StCmp: begin
        if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP)) begin
          pass_d = 1'b1;
          fail_d = 1'b0;
        end else begin
          pass_d = 1'b0;
          fail_d = 1'b1;
          if (!clear_errcnt && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
          end
        end
        state_d = StHold;
      end
      StHold: begin
        per_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      wait_q  <= 3'd0;
      per_q   <= '0;
      addr_q  <= 1'b0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      per_q   <= per_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  assign avm.avm_read    = (state_q == StRdId) || (state_q == StRdTs);
  // Address is registered so it holds its last value between strobes.
  assign avm.avm_address = addr_q;
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StHold);
  assign pass            = pass_q;
  assign fail            = fail_q;
  assign id_value        = id_q;
  assign ts_value        = ts_q;
  assign err_count       = err_q;

endmodule
